data_memory: RTL and testbench
==============================

# data_memory

Data memory (DM) stage of the single-cycle core. It is byte-addressable, word-organised storage serving RV32I loads and stores. Stores are written on the clock edge. Loads read combinationally, are aligned and sign/zero-extended, and drive the load-data input of the register-unit write-back selector in the same cycle. Misaligned, out-of-range and illegal-width accesses are detected, suppressed and logged in sticky fault registers.

## Interface
- DEPTH, 1024, number of 32-bit words; power of two, ≥ 4
- AW, $clog2(DEPTH), word-index width (derived, not overridden)

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- Address  in  32  byte address (ALU result)
- DataWr  in  32  store data (rs2 value)
- DMWr  in  1  store enable
- DMRd  in  1  load enable; qualifies fault detection only
- DMCtrl  in  3  access width/sign, RV32I funct3 encoding
- DataRd  out  32  extended load data
- Fault  out  1  current access is faulting (combinational)
- FaultSticky  out  1  a fault has occurred since reset
- FaultAddr  out  32  Address of the first fault since reset

## Operation
- Decoding: idx = Address[AW+1:2], off = Address[1:0].
- DMCtrl values: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned. Codes 011/110/111 are illegal.
- Stores use the low bits of DataWr only:
  - byte: DataWr[7:0] to lane off
  - half: DataWr[15:0] to lanes off, off+1
  - word: all four lanes
  - untouched lanes keep their contents
- Loads select the byte or half at off and sign-extend (000, 001) or zero-extend (100, 101). A word load returns the word unchanged.
- An access is active when DMWr or DMRd is 1. An active access faults when any of these holds:
  - half with off[0]=1
  - word with off≠0
  - DMCtrl is illegal
  - Address ≥ DEPTH*4
- Faulting store: no lane is written.
- Faulting load: DataRd = 0. A non-faulting read still returns the extended data even when DMRd=0.
- Fault = fault condition AND active access. It is never asserted when DMWr = DMRd = 0, regardless of Address.
- First Fault after reset: FaultSticky←1 and FaultAddr←Address on the same edge. Later faults do not change FaultAddr.
- DMWr and DMRd both 1: the write occurs. DataRd shows the pre-edge contents, i.e. read-before-write.
- Store forwarding: none; the updated value is visible on the cycle after the edge.

## Timing
- Read path is fully combinational: Address/DMCtrl → DataRd and Fault, with zero latency.
- Write latency is one edge; the data is readable in the next cycle.
- Reset (rst_n=0 at an edge):
  - every memory word becomes 0
  - FaultSticky=0, FaultAddr=0
  - reset wins over a simultaneous store or fault on the same edge
- Before the first reset edge, memory and fault registers are undefined. DataRd and Fault are never registered.
- Reset asserted mid-program: the next edge clears everything. The store presented on that edge is lost.

## Structure
- Package dm_pkg holds:
  - typedef enum logic [2:0] dm_ctrl_e (DM_LB=000, DM_LH=001, DM_LW=010, DM_LBU=100, DM_LHU=101)
  - a function is_legal_ctrl
  - the default DEPTH constant
- Storage is an array of DEPTH words with per-lane byte-enable write logic.
- Sub-module dm_load_ext is combinational: word, off, DMCtrl → extended DataRd. It is reused later by any load-path variant.
- Fault decode and the sticky registers live in the top module.

## Test plan
- Reset, then SW 0x8765_4321 at 0x10; next cycle LW 0x10 → DataRd=0x8765_4321 and Fault=0.
- SB 0xAB at 0x13 over that word → LW 0x10 gives 0xAB65_4321. Then:
  - LB 0x13 → 0xFFFF_FFAB
  - LBU 0x13 → 0x0000_00AB
- Halfword loads at 0x12 on word 0x8765_4321:
  - LH 0x12 → 0xFFFF_8765
  - LHU 0x12 → 0x0000_8765
- SW at 0x11 with data 0xFFFF_FFFF:
  - Fault=1 that cycle, and the word at 0x10 is unchanged
  - FaultSticky=1, FaultAddr=0x11
  - a later LW at DEPTH*4 (=0x1000) faults with DataRd=0, and FaultAddr stays 0x11
- DMCtrl=011 with DMRd=1 → Fault=1 and DataRd=0. Address=0x1000 with DMRd=DMWr=0 → Fault=0.
- rst_n=0 for one edge, with a SW 0x1234_5678 at 0x20 presented on that same edge:
  - LW 0x20 afterwards → 0
  - FaultSticky=0, FaultAddr=0

Source files
------------

// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dm_pkg
// Description : Shared types, constants and helpers for the data memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
package dm_pkg;

    localparam int DM_DEPTH_DEFAULT = 1024;

    typedef enum logic [2:0] {
        DM_LB  = 3'b000,
        DM_LH  = 3'b001,
        DM_LW  = 3'b010,
        DM_LBU = 3'b100,
        DM_LHU = 3'b101
    } dm_ctrl_e;

    function automatic logic is_legal_ctrl(input logic [2:0] ctrl);
        case (ctrl)
            DM_LB, DM_LH, DM_LW, DM_LBU, DM_LHU: is_legal_ctrl = 1'b1;
            default:                             is_legal_ctrl = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_load_ext.sv
`default_nettype none
// ============================================================================
// Module      : dm_load_ext
// Description : Selects the byte/half/word at a lane offset and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_ctrl,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_word >> {i_off, 3'b000};

    always_comb begin
        o_data = '0;
        case (i_ctrl)
            DM_LB:   o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            DM_LBU:  o_data = {24'h0, w_shifted[7:0]};
            DM_LH:   o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            DM_LHU:  o_data = {16'h0, w_shifted[15:0]};
            DM_LW:   o_data = i_word;
            default: o_data = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Byte-addressable RV32I data memory with sticky fault logging.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH_DEFAULT
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic        DMRd,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd,
    output logic        Fault,
    output logic        FaultSticky,
    output logic [31:0] FaultAddr
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [32:0] c_BYTES = 33'(DEPTH) << 2;

    logic [31:0]   r_mem [DEPTH];
    logic          r_sticky;
    logic [31:0]   r_faddr;

    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic          w_oor;
    logic          w_misalign;
    logic          w_fault_cond;
    logic          w_active;
    logic          w_we;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_ext;

    assign w_idx    = Address[AW+1:2];
    assign w_off    = Address[1:0];
    assign w_oor    = ({1'b0, Address} >= c_BYTES);
    assign w_active = DMWr | DMRd;

    // DMCtrl[1:0] carries the access size for every legal code.
    assign w_misalign   = ((DMCtrl[1:0] == 2'b01) && w_off[0]) ||
                          ((DMCtrl[1:0] == 2'b10) && (w_off != 2'b00));
    assign w_fault_cond = !is_legal_ctrl(DMCtrl) || w_misalign || w_oor;
    assign w_we         = DMWr && !w_fault_cond;

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = DataWr;
        case (DMCtrl[1:0])
            2'b00: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{DataWr[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << w_off;
                w_wdata = {2{DataWr[15:0]}};
            end
            2'b10: begin
                w_be    = 4'b1111;
                w_wdata = DataWr;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = DataWr;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) begin
                    r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
                end
            end
        end
    end

    // Only the first fault after reset records its address.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_faddr  <= '0;
        end else if (Fault && !r_sticky) begin
            r_sticky <= 1'b1;
            r_faddr  <= Address;
        end
    end

    assign w_rd_word = r_mem[w_idx];

    dm_load_ext u_load_ext (
        .i_word (w_rd_word),
        .i_off  (w_off),
        .i_ctrl (DMCtrl),
        .o_data (w_ext)
    );

    assign Fault       = w_fault_cond && w_active;
    assign DataRd      = Fault ? 32'h0 : w_ext;
    assign FaultSticky = r_sticky;
    assign FaultAddr   = r_faddr;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Directed vector table plus randomized run against a byte model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    localparam int DEPTH = 1024;
    localparam int NBYTE = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Address, DataWr;
    logic        DMWr, DMRd;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd, FaultAddr;
    logic        Fault, FaultSticky;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Address     (Address),
        .DataWr      (DataWr),
        .DMWr        (DMWr),
        .DMRd        (DMRd),
        .DMCtrl      (DMCtrl),
        .DataRd      (DataRd),
        .Fault       (Fault),
        .FaultSticky (FaultSticky),
        .FaultAddr   (FaultAddr)
    );

    typedef struct {
        logic        rst_n, wr, rd;
        logic [2:0]  ctrl;
        logic [31:0] addr, wdata;
        logic        chk, chk_data;
        logic [31:0] exp_data;
        logic        exp_fault, exp_sticky;
        logic [31:0] exp_faddr;
    } vec_t;

    vec_t        tbl[$];
    logic [7:0]  m_mem [NBYTE];
    logic        m_sticky;
    logic [31:0] m_faddr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rn, input logic wr, input logic rd, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic c,
                       input logic cd, input logic [31:0] ed, input logic ef,
                       input logic es, input logic [31:0] ea);
        vec_t v;
        v.rst_n = rn; v.wr = wr; v.rd = rd; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata;
        v.chk = c; v.chk_data = cd; v.exp_data = ed; v.exp_fault = ef;
        v.exp_sticky = es; v.exp_faddr = ea;
        tbl.push_back(v);
    endtask

    // Access size in bytes from the funct3 code; 0 means the code is illegal.
    function automatic int size_of(input logic [2:0] ctrl);
        case (ctrl)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic logic m_bad(input logic [2:0] ctrl, input logic [31:0] addr);
        int sz = size_of(ctrl);
        if (sz == 0) return 1'b1;
        if (addr >= 32'(NBYTE)) return 1'b1;
        return (addr % sz) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] ctrl, input logic [31:0] addr);
        int sz = size_of(ctrl);
        logic [31:0] v = '0;
        for (int k = 0; k < sz; k++) v = v | (32'(m_mem[addr + k]) << (8 * k));
        if (!ctrl[2] && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (!ctrl[2] && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NBYTE; k++) m_mem[k] = 8'h00;
        m_sticky = 1'b0;
        m_faddr  = '0;
    endtask

    task automatic m_edge(input logic rn, input logic wr, input logic rd, input logic [2:0] ctrl,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic bad = m_bad(ctrl, addr);
        if (!rn) begin
            m_reset();
        end else begin
            if (wr && !bad)
                for (int k = 0; k < size_of(ctrl); k++) m_mem[addr + k] = wdata[8*k +: 8];
            if ((wr || rd) && bad && !m_sticky) begin
                m_sticky = 1'b1;
                m_faddr  = addr;
            end
        end
    endtask

    task automatic drive(input logic rn, input logic wr, input logic rd, input logic [2:0] ctrl,
                         input logic [31:0] addr, input logic [31:0] wdata);
        rst_n = rn; DMWr = wr; DMRd = rd; DMCtrl = ctrl; Address = addr; DataWr = wdata;
        #2;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        bad, act;
        logic [31:0] a, d;
        logic [2:0]  c;
        logic        wr, rd, rn;

        // rst_n, wr, rd, ctrl, addr, wdata, chk, chk_data, exp_data, exp_fault, exp_sticky, exp_faddr
        add(0, 0, 0, 3'd2, 32'h0,    32'h0,         0, 0, 32'h0,         0, 0, 32'h0);
        add(1, 1, 0, 3'd2, 32'h10,   32'h8765_4321, 1, 1, 32'h0,         0, 0, 32'h0);
        add(1, 0, 1, 3'd2, 32'h10,   32'h0,         1, 1, 32'h8765_4321, 0, 0, 32'h0);
        add(1, 1, 0, 3'd0, 32'h13,   32'h0000_00AB, 1, 1, 32'hFFFF_FF87, 0, 0, 32'h0);
        add(1, 0, 1, 3'd2, 32'h10,   32'h0,         1, 1, 32'hAB65_4321, 0, 0, 32'h0);
        add(1, 0, 1, 3'd0, 32'h13,   32'h0,         1, 1, 32'hFFFF_FFAB, 0, 0, 32'h0);
        add(1, 0, 1, 3'd4, 32'h13,   32'h0,         1, 1, 32'h0000_00AB, 0, 0, 32'h0);
        add(1, 1, 0, 3'd2, 32'h10,   32'h8765_4321, 1, 0, 32'h0,         0, 0, 32'h0);
        add(1, 0, 1, 3'd1, 32'h12,   32'h0,         1, 1, 32'hFFFF_8765, 0, 0, 32'h0);
        add(1, 0, 1, 3'd5, 32'h12,   32'h0,         1, 1, 32'h0000_8765, 0, 0, 32'h0);
        add(1, 1, 0, 3'd2, 32'h11,   32'hFFFF_FFFF, 1, 1, 32'h0,         1, 0, 32'h0);
        add(1, 0, 1, 3'd2, 32'h10,   32'h0,         1, 1, 32'h8765_4321, 0, 1, 32'h11);
        add(1, 0, 1, 3'd2, 32'h1000, 32'h0,         1, 1, 32'h0,         1, 1, 32'h11);
        add(1, 0, 1, 3'd3, 32'h10,   32'h0,         1, 1, 32'h0,         1, 1, 32'h11);
        add(1, 0, 0, 3'd2, 32'h1000, 32'h0,         1, 0, 32'h0,         0, 1, 32'h11);
        add(0, 1, 0, 3'd2, 32'h20,   32'h1234_5678, 1, 0, 32'h0,         0, 1, 32'h11);
        add(1, 0, 1, 3'd2, 32'h20,   32'h0,         1, 1, 32'h0,         0, 0, 32'h0);
        add(1, 1, 1, 3'd5, 32'h22,   32'h0000_BEEF, 1, 1, 32'h0,         0, 0, 32'h0);
        add(1, 0, 1, 3'd2, 32'h20,   32'h0,         1, 1, 32'hBEEF_0000, 0, 0, 32'h0);
        add(1, 0, 1, 3'd1, 32'h22,   32'h0,         1, 1, 32'hFFFF_BEEF, 0, 0, 32'h0);

        m_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].wr, tbl[i].rd, tbl[i].ctrl, tbl[i].addr, tbl[i].wdata);
            if (tbl[i].chk) begin
                chk($sformatf("vec%0d_fault", i), 32'(Fault), 32'(tbl[i].exp_fault));
                chk($sformatf("vec%0d_sticky", i), 32'(FaultSticky), 32'(tbl[i].exp_sticky));
                chk($sformatf("vec%0d_faddr", i), FaultAddr, tbl[i].exp_faddr);
                if (tbl[i].chk_data)
                    chk($sformatf("vec%0d_data", i), DataRd, tbl[i].exp_data);
            end
            clock_edge();
        end

        // Randomized run against the byte-level model, starting from reset.
        drive(1'b0, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
        m_edge(1'b0, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
        clock_edge();
        for (int n = 0; n < 600; n++) begin
            rn = ($urandom_range(0, 79) != 0);
            wr = $urandom_range(0, 1);
            rd = $urandom_range(0, 1);
            c  = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 19) == 0) ? 32'(NBYTE) + $urandom_range(0, 8) - 4
                                              : 32'($urandom_range(0, 63));
            d  = $urandom;
            drive(rn, wr, rd, c, a, d);
            bad = m_bad(c, a);
            act = wr | rd;
            chk("rnd_fault", 32'(Fault), 32'(bad && act));
            chk("rnd_sticky", 32'(FaultSticky), 32'(m_sticky));
            chk("rnd_faddr", FaultAddr, m_faddr);
            if (bad && act)      chk("rnd_data_fault", DataRd, 32'h0);
            else if (!bad)       chk("rnd_data", DataRd, m_load(c, a));
            m_edge(rn, wr, rd, c, a, d);
            clock_edge();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
